// File: rtl/serial_input_fifo.sv
// Serial-to-parallel sensor input stage: assembles DATA_WIDTH-bit words from a
// qualified bitstream and queues them in a DEPTH-entry FIFO with overflow flag.
module serial_input_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LSB_FIRST  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sensor_data,
  input  logic                    sensor_valid,
  input  logic                    data_processed,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   data_output,
  output logic                    data_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_next;
  logic                  clear;
  logic                  word_done;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // Push/pop decisions; a pop on a full FIFO frees the slot the push lands in.
  always_comb begin
    shift_next = (LSB_FIRST != 0) ? {sensor_data, shift_reg[DATA_WIDTH-1:1]}
                                  : {shift_reg[DATA_WIDTH-2:0], sensor_data};
    clear      = reset | flush;
    word_done  = sensor_valid & (bit_cnt == LAST_BIT);
    full       = (count == FULL_CNT);
    pop        = data_ready & data_processed;
    push       = word_done & (~full | pop);
    drop       = word_done & full & ~pop;
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Assembly, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (clear) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_ready <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (sensor_valid) begin
        shift_reg <= shift_next;
        bit_cnt   <= word_done ? '0 : bit_cnt + BIT_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_next;
      data_ready <= (count_next != '0);
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the head is gated whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= shift_next;
  end

  assign data_output = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_serial_input_fifo.sv
// Bench for serial_input_fifo: MSB-first and LSB-first instances share stimulus
// and are checked against a queue-based model of bit collection and the FIFO.
module tb_serial_input_fifo;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D) + 1;
  localparam int unsigned VW = W + CW + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, sensor_data = 1'b0, sensor_valid = 1'b0;
  logic data_processed = 1'b0, flush = 1'b0;
  logic [W-1:0]  out_m, out_l;
  logic          rdy_m, rdy_l, ovf_m, ovf_l;
  logic [CW-1:0] cnt_m, cnt_l;

  serial_input_fifo #(.DATA_WIDTH(W), .DEPTH(D), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .reset(reset), .sensor_data(sensor_data), .sensor_valid(sensor_valid),
    .data_processed(data_processed), .flush(flush), .data_output(out_m),
    .data_ready(rdy_m), .count(cnt_m), .overflow(ovf_m));

  serial_input_fifo #(.DATA_WIDTH(W), .DEPTH(D), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .reset(reset), .sensor_data(sensor_data), .sensor_valid(sensor_valid),
    .data_processed(data_processed), .flush(flush), .data_output(out_l),
    .data_ready(rdy_l), .count(cnt_l), .overflow(ovf_l));

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: pending bits plus one word queue per bit order.
  bit           bits_q[$];
  logic [W-1:0] fm[$];
  logic [W-1:0] fl[$];
  bit           m_ovf = 1'b0;

  function automatic void model_edge(input bit v, input bit d, input bit p, input bit f, input bit r);
    bit was_full, do_pop;
    logic [W-1:0] wm, wl;
    if (r || f) begin
      bits_q.delete(); fm.delete(); fl.delete(); m_ovf = 1'b0;
      return;
    end
    was_full = (fm.size() == D);
    do_pop   = p && (fm.size() != 0);
    if (do_pop) begin
      void'(fm.pop_front());
      void'(fl.pop_front());
    end
    if (v) begin
      bits_q.push_back(d);
      if (bits_q.size() == W) begin
        wm = '0; wl = '0;
        for (int i = 0; i < W; i++) begin
          wm = wm + (W'(bits_q[i]) << (W - 1 - i));
          wl = wl + (W'(bits_q[i]) << i);
        end
        bits_q.delete();
        if (!was_full || do_pop) begin
          fm.push_back(wm);
          fl.push_back(wl);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec(input bit lsb);
    logic [W-1:0] o;
    o = '0;
    if (fm.size() != 0) o = lsb ? fl[0] : fm[0];
    return {o, fm.size() != 0, CW'(fm.size()), m_ovf};
  endfunction

  task automatic step(input bit v, input bit d, input bit p, input bit f, input bit r);
    sensor_valid = v; sensor_data = d; data_processed = p; flush = f; reset = r;
    @(posedge clk);
    model_edge(v, d, p, f, r);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap, input bit pop_last);
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b1, w[i], pop_last && (i == 0), 1'b0, 1'b0);
      if (i > 0) for (int g = 0; g < gap; g++) step(1'b0, g[0], 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({out_m, rdy_m, cnt_m, ovf_m} !== VW'(0)) begin
      n_fail++; $display("FAIL reset_msb got %h want %h", {out_m, rdy_m, cnt_m, ovf_m}, VW'(0));
    end
    n_cmp++;
    if ({out_l, rdy_l, cnt_l, ovf_l} !== VW'(0)) begin
      n_fail++; $display("FAIL reset_lsb got %h want %h", {out_l, rdy_l, cnt_l, ovf_l}, VW'(0));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_word_order;
    send_word(8'hB2, 0, 1'b0);
    n_cmp++;
    if ({out_m, rdy_m, cnt_m} !== {8'hB2, 1'b1, CW'(1)}) begin
      n_fail++; $display("FAIL msb_word got %h/%b/%0d want b2/1/1", out_m, rdy_m, cnt_m);
    end
    n_cmp++;
    if ({out_l, rdy_l, cnt_l} !== {8'h4D, 1'b1, CW'(1)}) begin
      n_fail++; $display("FAIL lsb_word got %h/%b/%0d want 4d/1/1", out_l, rdy_l, cnt_l);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({out_m, rdy_m, cnt_m} !== {8'h00, 1'b0, CW'(0)}) begin
      n_fail++; $display("FAIL word_pop got %h/%b/%0d want 00/0/0", out_m, rdy_m, cnt_m);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({out_m, rdy_m, cnt_m, ovf_m} !== exp_vec(0)) begin
      n_fail++; $display("FAIL pop_empty got %h want %h", {out_m, rdy_m, cnt_m, ovf_m}, exp_vec(0));
    end
  endtask

  task automatic test_gapped;
    bit early_push = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b1, i[0] ^ 1'b1 ^ ((8'hB2 >> i) & 1'b1) ^ i[0] ^ 1'b1, 1'b0, 1'b0, 1'b0);
      if (i > 0) begin
        if (cnt_m !== CW'(0)) early_push = 1'b1;
        for (int g = 0; g < 3; g++) begin
          step(1'b0, g[0] ^ i[0], 1'b0, 1'b0, 1'b0);
          if (cnt_m !== CW'(0)) early_push = 1'b1;
        end
      end
    end
    n_cmp++;
    if (early_push) begin
      n_fail++; $display("FAIL gap_early_push got count>0 before last bit want 0");
    end
    n_cmp++;
    if ({out_m, rdy_m, cnt_m} !== {8'hB2, 1'b1, CW'(1)}) begin
      n_fail++; $display("FAIL gap_word got %h/%b/%0d want b2/1/1", out_m, rdy_m, cnt_m);
    end
    n_cmp++;
    if ({out_l, rdy_l, cnt_l, ovf_l} !== exp_vec(1)) begin
      n_fail++; $display("FAIL gap_lsb got %h want %h", {out_l, rdy_l, cnt_l, ovf_l}, exp_vec(1));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overflow;
    logic [W-1:0] want;
    for (int k = 1; k <= 4; k++) send_word(W'(k * 8'h11), 0, 1'b0);
    n_cmp++;
    if ({cnt_m, ovf_m} !== {CW'(4), 1'b0}) begin
      n_fail++; $display("FAIL fill got count %0d ovf %b want 4 0", cnt_m, ovf_m);
    end
    send_word(8'h55, 0, 1'b0);
    n_cmp++;
    if ({out_m, cnt_m, ovf_m} !== {8'h11, CW'(4), 1'b1}) begin
      n_fail++; $display("FAIL drop got %h/%0d/%b want 11/4/1", out_m, cnt_m, ovf_m);
    end
    n_cmp++;
    if ({out_l, rdy_l, cnt_l, ovf_l} !== exp_vec(1)) begin
      n_fail++; $display("FAIL drop_lsb got %h want %h", {out_l, rdy_l, cnt_l, ovf_l}, exp_vec(1));
    end
    for (int k = 1; k <= 4; k++) begin
      want = W'(k * 8'h11);
      n_cmp++;
      if (out_m !== want) begin
        n_fail++; $display("FAIL ovf_order%0d got %h want %h", k, out_m, want);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    n_cmp++;
    if ({rdy_m, cnt_m, ovf_m} !== {1'b0, CW'(0), 1'b1}) begin
      n_fail++; $display("FAIL ovf_sticky got %b/%0d/%b want 0/0/1", rdy_m, cnt_m, ovf_m);
    end
  endtask

  task automatic test_push_pop_full;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) send_word(W'(k * 8'h11), 0, 1'b0);
    send_word(8'h55, 0, 1'b1);
    n_cmp++;
    if ({out_m, cnt_m, ovf_m} !== {8'h22, CW'(4), 1'b0}) begin
      n_fail++; $display("FAIL full_pushpop got %h/%0d/%b want 22/4/0", out_m, cnt_m, ovf_m);
    end
    n_cmp++;
    if ({out_l, rdy_l, cnt_l, ovf_l} !== exp_vec(1)) begin
      n_fail++; $display("FAIL full_pushpop_lsb got %h want %h", {out_l, rdy_l, cnt_l, ovf_l}, exp_vec(1));
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({out_m, cnt_m} !== {8'h55, CW'(1)}) begin
      n_fail++; $display("FAIL full_last got %h/%0d want 55/1", out_m, cnt_m);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_clear(input bit use_reset);
    for (int k = 1; k <= 5; k++) send_word(W'(k * 8'h11), 0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({cnt_m, ovf_m} !== {CW'(2), 1'b1}) begin
      n_fail++; $display("FAIL pre_clear%0d got %0d/%b want 2/1", use_reset, cnt_m, ovf_m);
    end
    step(1'b1, 1'b1, 1'b1, !use_reset, use_reset);
    n_cmp++;
    if ({out_m, rdy_m, cnt_m, ovf_m} !== VW'(0)) begin
      n_fail++; $display("FAIL clear%0d got %h want %h", use_reset, {out_m, rdy_m, cnt_m, ovf_m}, VW'(0));
    end
    send_word(8'hA5, 0, 1'b0);
    n_cmp++;
    if ({out_m, rdy_m, cnt_m, ovf_m} !== {8'hA5, 1'b1, CW'(1), 1'b0}) begin
      n_fail++; $display("FAIL post_clear%0d got %h/%0d want a5/1", use_reset, out_m, cnt_m);
    end
    n_cmp++;
    if ({out_l, rdy_l, cnt_l, ovf_l} !== exp_vec(1)) begin
      n_fail++; $display("FAIL post_clear_lsb%0d got %h want %h", use_reset, {out_l, rdy_l, cnt_l, ovf_l}, exp_vec(1));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    bit v, d, p, f, r;
    for (int c = 0; c < 3000; c++) begin
      v = ($urandom_range(0, 3) != 0);
      d = $urandom_range(0, 1);
      p = (c < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      f = ($urandom_range(0, 150) == 0);
      r = ($urandom_range(0, 300) == 0);
      step(v, d, p, f, r);
      n_cmp++;
      if ({out_m, rdy_m, cnt_m, ovf_m} !== exp_vec(0)) begin
        n_fail++; $display("FAIL rand_msb c%0d got %h want %h", c, {out_m, rdy_m, cnt_m, ovf_m}, exp_vec(0));
      end
      n_cmp++;
      if ({out_l, rdy_l, cnt_l, ovf_l} !== exp_vec(1)) begin
        n_fail++; $display("FAIL rand_lsb c%0d got %h want %h", c, {out_l, rdy_l, cnt_l, ovf_l}, exp_vec(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_order();
    test_gapped();
    test_overflow();
    test_push_pop_full();
    test_clear(1'b0);
    test_clear(1'b1);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
